discus_core: RTL and testbench

- Parametrised successor to the 8-bit discus CPU.
- Generalises data width, register count, memory depth and return-stack depth.
- Uses a simple multi-cycle FSM in place of the overlapped pipeline.
- Adds HALT, return-stack overflow/underflow fault detection, run/single-step control, and a single-clock debug port for loading and inspecting program and data memory.
- Sits at top level behind the board/host debug interface.

---
 rtl/discus_core.sv | 183 ++++++++++++++++++
 tb/tb_discus_core.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/discus_core.sv
// discus_core: parametrised multi-cycle discus CPU with a return stack, halt/fault
// detection, run/single-step control and a single-clock debug port into both memories.
module discus_core #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int NREGS       = 4,
    parameter int STACK_DEPTH = 4,
    localparam int RW         = $clog2(NREGS),
    localparam int INSN_W     = 4 + RW + DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic              step,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [INSN_W-1:0] dbg_wdata,
    input  logic              dbg_we_prog,
    input  logic              dbg_we_data,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [1:0]        fault,
    output logic              retire
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int SPW   = $clog2(STACK_DEPTH + 1);
    localparam int SIW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [3:0] {
        OP_NOP, OP_LDI, OP_LD,  OP_ST,  OP_ADD, OP_ADC, OP_SUB, OP_AND,
        OP_OR,  OP_XOR, OP_INC, OP_DEC, OP_JMP, OP_CALL, OP_RET, OP_HALT
    } op_e;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_e;

    state_e            state;
    logic [INSN_W-1:0] prog_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DATA_W-1:0] regs [NREGS];
    logic [ADDR_W-1:0] stack [1 << SIW];
    logic [SPW-1:0]    sp;
    logic              c_flag, z_flag;
    logic [INSN_W-1:0] ir;
    logic [DATA_W-1:0] mem_q;

    op_e               op;
    logic [RW-1:0]     rsel;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] target, pc_inc;
    logic [SPW-1:0]    sp_dec;
    logic              stall, st_commit;

    assign op        = op_e'(ir[INSN_W-1 -: 4]);
    assign rsel      = ir[DATA_W +: RW];
    assign imm       = ir[DATA_W-1:0];
    assign target    = imm[ADDR_W-1:0];
    assign pc_inc    = pc + ADDR_W'(1);
    assign sp_dec    = sp - SPW'(1);
    assign stall     = dbg_we_prog | dbg_we_data;
    assign st_commit = reset_n && !stall && (state == S_EXEC) && (op == OP_ST);

    logic [DATA_W-1:0] opnd, alu_res;
    logic              alu_c, jmp_take;

    // Register 0 is A, so an ALU op with r=0 naturally uses A as its own operand.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        opnd     = regs[rsel];
        alu_res  = regs[0];
        alu_c    = c_flag;
        jmp_take = 1'b0;
        case (op)
            OP_ADD: {alu_c, alu_res} = {1'b0, regs[0]} + {1'b0, opnd};
            OP_ADC: {alu_c, alu_res} = {1'b0, regs[0]} + {1'b0, opnd} + (DATA_W+1)'(c_flag);
            OP_SUB: {alu_c, alu_res} = {1'b0, regs[0]} + {1'b0, ~opnd} + (DATA_W+1)'(1);
            OP_AND: alu_res = regs[0] & opnd;
            OP_OR:  alu_res = regs[0] | opnd;
            OP_XOR: alu_res = regs[0] ^ opnd;
            OP_INC: alu_res = opnd + DATA_W'(1);
            OP_DEC: alu_res = opnd - DATA_W'(1);
            default: ;
        endcase
        case (rsel[1:0])
            2'b00: jmp_take = 1'b1;
            2'b01: jmp_take = z_flag;
            2'b10: jmp_take = !z_flag;
            2'b11: jmp_take = c_flag;
            default: ;
        endcase
    end

    // NOTE: memories carry no reset; a store is gated by reset_n so a reset edge drops it.
    always_ff @(posedge clk) begin
        if (dbg_we_prog) prog_mem[dbg_addr] <= dbg_wdata;
        if (dbg_we_data) data_mem[dbg_addr] <= dbg_wdata[DATA_W-1:0];
        if (st_commit)   data_mem[target]   <= regs[rsel];
        mem_q <= data_mem[target];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_FETCH;
            pc        <= '0;
            sp        <= '0;
            c_flag    <= 1'b0;
            z_flag    <= 1'b0;
            halted    <= 1'b0;
            fault     <= 2'b00;
            retire    <= 1'b0;
            ir        <= '0;
            dbg_rdata <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            retire    <= 1'b0;
            dbg_rdata <= data_mem[dbg_addr];
            if (!stall) begin
                case (state)
                    S_FETCH: if (run || step) begin
                        ir    <= prog_mem[pc];
                        state <= S_EXEC;
                    end
                    S_EXEC: begin
                        state  <= S_FETCH;
                        retire <= 1'b1;
                        pc     <= pc_inc;
                        case (op)
                            OP_LDI: regs[rsel] <= imm;
                            OP_LD: begin
                                state  <= S_MEM;
                                retire <= 1'b0;
                            end
                            OP_ADD, OP_ADC, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                                regs[0] <= alu_res;
                                c_flag  <= alu_c;
                                z_flag  <= (alu_res == '0);
                            end
                            OP_INC, OP_DEC: begin
                                regs[rsel] <= alu_res;
                                z_flag     <= (alu_res == '0);
                            end
                            OP_JMP: if (jmp_take) pc <= target;
                            OP_CALL: if (sp == SPW'(STACK_DEPTH)) begin
                                pc     <= pc;
                                fault  <= 2'b01;
                                halted <= 1'b1;
                                retire <= 1'b0;
                                state  <= S_HALT;
                            end else begin
                                stack[sp[SIW-1:0]] <= pc_inc;
                                sp <= sp + SPW'(1);
                                pc <= target;
                            end
                            OP_RET: if (sp == '0) begin
                                pc     <= pc;
                                fault  <= 2'b10;
                                halted <= 1'b1;
                                retire <= 1'b0;
                                state  <= S_HALT;
                            end else begin
                                pc <= stack[sp_dec[SIW-1:0]];
                                sp <= sp_dec;
                            end
                            OP_HALT: begin
                                pc     <= pc;
                                halted <= 1'b1;
                                retire <= 1'b0;
                                state  <= S_HALT;
                            end
                            default: ;
                        endcase
                    end
                    S_MEM: begin
                        regs[rsel] <= mem_q;
                        retire     <= 1'b1;
                        state      <= S_FETCH;
                    end
                    S_HALT: ;
                    default: state <= S_FETCH;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_discus_core.sv
// Bench for discus_core: directed scenarios plus random programs compared against an
// instruction-level reference interpreter.
module tb_discus_core;
    localparam int DW = 8, AW = 8, NR = 4, SD = 4, IW = 4 + 2 + DW;
    localparam int DW2 = 16, NR2 = 8, IW2 = 4 + 3 + DW2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, run, step, dbg_we_prog, dbg_we_data, halted, retire;
    logic [AW-1:0] dbg_addr, pc;
    logic [IW-1:0] dbg_wdata;
    logic [DW-1:0] dbg_rdata;
    logic [1:0]    fault;

    logic           reset_n_b, run_b, step_b, we_prog_b, we_data_b, halted_b, retire_b;
    logic [AW-1:0]  addr_b, pc_b;
    logic [IW2-1:0] wdata_b;
    logic [DW2-1:0] rdata_b;
    logic [1:0]     fault_b;

    discus_core #(.DATA_W(DW), .ADDR_W(AW), .NREGS(NR), .STACK_DEPTH(SD)) u_dut (
        .clk(clk), .reset_n(reset_n), .run(run), .step(step),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_we_prog(dbg_we_prog),
        .dbg_we_data(dbg_we_data), .dbg_rdata(dbg_rdata), .pc(pc), .halted(halted),
        .fault(fault), .retire(retire)
    );

    discus_core #(.DATA_W(DW2), .ADDR_W(AW), .NREGS(NR2), .STACK_DEPTH(2)) u_dut_b (
        .clk(clk), .reset_n(reset_n_b), .run(run_b), .step(step_b),
        .dbg_addr(addr_b), .dbg_wdata(wdata_b), .dbg_we_prog(we_prog_b),
        .dbg_we_data(we_data_b), .dbg_rdata(rdata_b), .pc(pc_b), .halted(halted_b),
        .fault(fault_b), .retire(retire_b)
    );

    int n_vec = 0, n_bad = 0, ret_cnt = 0;
    int p_op[64], p_r[64], p_imm[64];
    int wp;
    int dmem_img[32];
    int m_mem[64];
    int m_ret, m_cyc, m_pc, m_fault;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (retire) ret_cnt++;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) begin
            p_op[i] = 15; p_r[i] = 0; p_imm[i] = 0;
        end
        wp = 0;
    endtask

    task automatic emit(input int op, input int r, input int imm);
        p_op[wp] = op; p_r[wp] = r; p_imm[wp] = imm;
        wp++;
    endtask

    // Copies C into data[m] and Z into data[m+1] using r2/r3; touches no flags.
    task automatic emit_dump(input int m);
        int s;
        s = wp;
        emit(1, 2, 0);  emit(1, 3, 0);
        emit(12, 3, s + 4); emit(12, 0, s + 5); emit(1, 2, 1);
        emit(12, 1, s + 7); emit(12, 0, s + 8); emit(1, 3, 1);
        emit(3, 2, m);  emit(3, 3, m + 1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; run = 1'b0; step = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        ret_cnt = 0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 64; i++) begin
            dbg_addr = AW'(i);
            dbg_wdata = {p_op[i][3:0], p_r[i][1:0], p_imm[i][7:0]};
            dbg_we_prog = 1'b1;
            tick();
        end
        dbg_we_prog = 1'b0;
    endtask

    task automatic load_data();
        for (int i = 0; i < 32; i++) begin
            dbg_addr = AW'(i);
            dbg_wdata = {6'b0, dmem_img[i][7:0]};
            dbg_we_data = 1'b1;
            tick();
        end
        dbg_we_data = 1'b0;
    endtask

    task automatic rd(input int a, output int v);
        dbg_addr = AW'(a);
        tick();
        v = int'(dbg_rdata);
    endtask

    task automatic wait_halt(input int budget, output int cyc);
        cyc = 0;
        while (!halted && cyc < budget) begin
            tick();
            cyc++;
        end
        check("halt_reached", halted, 1);
    endtask

    task automatic gen_random();
        clear_prog();
        for (int i = 0; i < 48; i++) begin
            int op;
            op = $urandom_range(0, 14);
            if (op == 14 && $urandom_range(0, 2) != 0) op = 0;
            p_op[i] = op;
            p_r[i] = $urandom_range(0, 3);
            case (op)
                2:       p_imm[i] = $urandom_range(0, 31);
                3:       p_imm[i] = $urandom_range(0, 25);
                12, 13:  p_imm[i] = $urandom_range(i + 1, 48);
                default: p_imm[i] = $urandom_range(0, 255);
            endcase
        end
        wp = 48;
        emit(3, 0, 28); emit(3, 1, 29); emit(3, 2, 30); emit(3, 3, 31);
        emit_dump(26);
        for (int i = 0; i < 32; i++) dmem_img[i] = $urandom_range(0, 255);
    endtask

    // Instruction-level interpreter: one loop iteration per architectural instruction.
    task automatic model_run(output bit ok);
        int a[4];
        int stk[$];
        int c, z, pcm, op, r, imm, rv, nxt, res;
        bit take;
        for (int i = 0; i < 4; i++) a[i] = 0;
        for (int i = 0; i < 64; i++) m_mem[i] = (i < 32) ? dmem_img[i] : 0;
        c = 0; z = 0; pcm = 0; m_ret = 0; m_cyc = 0; m_fault = 0; ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            op = p_op[pcm]; r = p_r[pcm]; imm = p_imm[pcm]; rv = a[r];
            m_cyc += 2;
            if (op == 15) begin ok = 1'b1; break; end
            if (op == 13 && stk.size() == SD) begin m_fault = 1; ok = 1'b1; break; end
            if (op == 14 && stk.size() == 0) begin m_fault = 2; ok = 1'b1; break; end
            nxt = (pcm + 1) % 256;
            case (op)
                1: a[r] = imm;
                2: begin a[r] = m_mem[imm]; m_cyc++; end
                3: m_mem[imm] = rv;
                4: begin res = a[0] + rv; c = int'(res > 255); a[0] = res % 256; z = int'(a[0] == 0); end
                5: begin res = a[0] + rv + c; c = int'(res > 255); a[0] = res % 256; z = int'(a[0] == 0); end
                6: begin c = int'(a[0] >= rv); a[0] = (a[0] - rv + 256) % 256; z = int'(a[0] == 0); end
                7: begin a[0] = a[0] & rv; z = int'(a[0] == 0); end
                8: begin a[0] = a[0] | rv; z = int'(a[0] == 0); end
                9: begin a[0] = a[0] ^ rv; z = int'(a[0] == 0); end
                10: begin a[r] = (rv + 1) % 256; z = int'(a[r] == 0); end
                11: begin a[r] = (rv + 255) % 256; z = int'(a[r] == 0); end
                12: begin
                    case (r & 3)
                        0: take = 1'b1;
                        1: take = (z != 0);
                        2: take = (z == 0);
                        default: take = (c != 0);
                    endcase
                    if (take) nxt = imm;
                end
                13: begin stk.push_back(nxt); nxt = imm; end
                14: nxt = stk.pop_back();
                default: ;
            endcase
            m_ret++;
            pcm = nxt;
        end
        m_pc = pcm;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v, cyc;
        bit ok;
        dbg_addr = '0; dbg_wdata = '0; dbg_we_prog = 1'b0; dbg_we_data = 1'b0;
        reset_n_b = 1'b0; run_b = 1'b0; step_b = 1'b0; we_prog_b = 1'b0; we_data_b = 1'b0;
        addr_b = '0; wdata_b = '0;

        // Reset state, observed while reset is still asserted.
        reset_n = 1'b0; run = 1'b0; step = 1'b0;
        tick(); tick();
        check("rst_pc", pc, 0);
        check("rst_halted", halted, 0);
        check("rst_fault", fault, 0);
        check("rst_retire", retire, 0);
        check("rst_rdata", dbg_rdata, 0);

        // LDI r1,5; LDI r0,250; ADD r1; HALT -> halted after 8 cycles, 3 retires.
        clear_prog();
        emit(1, 1, 5); emit(1, 0, 250); emit(4, 1, 0);
        do_reset(); load_prog(); ret_cnt = 0;
        run = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) check("t1_halted_c7", halted, 0);
            if (k == 8) check("t1_halted_c8", halted, 1);
        end
        run = 1'b0;
        check("t1_retires", ret_cnt, 3);
        check("t1_pc", pc, 3);
        check("t1_fault", fault, 0);
        wp = 3; emit(3, 0, 32); emit_dump(33);
        do_reset(); load_prog(); run = 1'b1; wait_halt(60, cyc); run = 1'b0;
        rd(32, v); check("t1_A", v, 255);
        rd(33, v); check("t1_C", v, 0);
        rd(34, v); check("t1_Z", v, 0);

        // ADD / ADC / SUB flag behaviour.
        clear_prog();
        emit(1, 0, 200); emit(1, 1, 100); emit(4, 1, 0); emit(3, 0, 36); emit_dump(37);
        emit(5, 1, 0); emit(3, 0, 39); emit_dump(40);
        emit(6, 0, 0); emit(3, 0, 42); emit_dump(43);
        do_reset(); load_prog(); run = 1'b1; wait_halt(200, cyc); run = 1'b0;
        rd(36, v); check("add_A", v, 44);
        rd(37, v); check("add_C", v, 1);
        rd(38, v); check("add_Z", v, 0);
        rd(39, v); check("adc_A", v, 145);
        rd(40, v); check("adc_C", v, 0);
        rd(41, v); check("adc_Z", v, 0);
        rd(42, v); check("sub_A", v, 0);
        rd(43, v); check("sub_C", v, 1);
        rd(44, v); check("sub_Z", v, 1);

        // Five nested CALLs overflow a 4-deep stack on the fifth.
        clear_prog();
        for (int i = 0; i < 5; i++) emit(13, 0, i + 1);
        do_reset(); load_prog(); ret_cnt = 0; run = 1'b1; wait_halt(40, cyc); run = 1'b0;
        check("ovf_fault", fault, 1);
        check("ovf_pc", pc, 4);
        check("ovf_retires", ret_cnt, 4);
        clear_prog(); emit(14, 0, 0);
        do_reset(); load_prog(); ret_cnt = 0; run = 1'b1; wait_halt(20, cyc); run = 1'b0;
        check("unf_fault", fault, 2);
        check("unf_pc", pc, 0);
        check("unf_retires", ret_cnt, 0);
        clear_prog(); emit(13, 0, 5); emit(3, 1, 46); wp = 5; emit(1, 1, 77); emit(14, 0, 0);
        do_reset(); load_prog(); ret_cnt = 0; run = 1'b1; wait_halt(40, cyc); run = 1'b0;
        check("call_pc", pc, 2);
        check("call_fault", fault, 0);
        check("call_retires", ret_cnt, 4);
        rd(46, v); check("call_mem", v, 77);

        // Single-step with run=0.
        clear_prog(); emit(0, 0, 0); emit(0, 0, 0); emit(0, 0, 0);
        do_reset(); load_prog(); ret_cnt = 0;
        tick(); tick(); tick(); tick();
        check("step_idle_pc", pc, 0);
        for (int s = 0; s < 3; s++) begin
            step = 1'b1; tick(); step = 1'b0;
            tick(); tick(); tick(); tick();
            check("step_pc", pc, s + 1);
        end
        check("step_retires", ret_cnt, 3);

        // Debug data write held for two cycles during the EXEC of an LD.
        for (int i = 0; i < 32; i++) dmem_img[i] = 0;
        dmem_img[5] = 11;
        clear_prog(); emit(2, 1, 5); emit(3, 1, 47);
        do_reset(); load_prog(); load_data(); ret_cnt = 0;
        run = 1'b1; tick();
        dbg_addr = 8'd5; dbg_wdata = 14'd99; dbg_we_data = 1'b1;
        tick(); tick();
        dbg_we_data = 1'b0;
        tick(); check("stall_retire_early", retire, 0);
        tick(); check("stall_retire_late", retire, 1);
        check("stall_retire_count", ret_cnt, 1);
        wait_halt(20, cyc); run = 1'b0;
        rd(47, v); check("stall_ld_value", v, 99);
        rd(5, v);  check("dbg_rdata_latency", v, 99);

        // Reset during MEM of an LD leaves the target register at 0.
        dmem_img[20] = 8'h5A;
        clear_prog(); emit(2, 1, 5); emit(3, 1, 20);
        do_reset(); load_prog(); load_data();
        run = 1'b1; tick(); tick();
        reset_n = 1'b0; run = 1'b0; tick(); reset_n = 1'b1;
        check("rstmem_pc", pc, 0);
        check("rstmem_retire", retire, 0);
        clear_prog(); emit(3, 1, 20);
        load_prog(); ret_cnt = 0; run = 1'b1; wait_halt(20, cyc); run = 1'b0;
        rd(20, v); check("rstmem_reg", v, 0);

        // Random programs against the reference interpreter.
        for (int t = 0; t < 20; t++) begin
            ok = 1'b0;
            while (!ok) begin
                gen_random();
                model_run(ok);
            end
            do_reset(); load_prog(); load_data(); ret_cnt = 0;
            run = 1'b1; wait_halt(m_cyc + 10, cyc); run = 1'b0;
            check("rand_cycles", cyc, m_cyc);
            check("rand_pc", pc, m_pc);
            check("rand_fault", fault, m_fault);
            check("rand_retires", ret_cnt, m_ret);
            for (int i = 0; i < 32; i++) begin
                rd(i, v);
                check("rand_mem", v, m_mem[i]);
            end
        end

        // Wide configuration: DATA_W=16, NREGS=8, DEC of 0 wraps to 0xFFFF with Z=0.
        clear_prog(); emit(11, 5, 0); emit(3, 5, 0); emit_dump(1);
        tick(); reset_n_b = 1'b1;
        for (int i = 0; i < 64; i++) begin
            addr_b = AW'(i);
            wdata_b = {p_op[i][3:0], p_r[i][2:0], p_imm[i][15:0]};
            we_prog_b = 1'b1;
            tick();
        end
        we_prog_b = 1'b0;
        run_b = 1'b1;
        cyc = 0;
        while (!halted_b && cyc < 60) begin tick(); cyc++; end
        run_b = 1'b0;
        check("w16_halted", halted_b, 1);
        check("w16_fault", fault_b, 0);
        addr_b = 8'd0; tick(); check("w16_dec", rdata_b, 32'hFFFF);
        addr_b = 8'd1; tick(); check("w16_C", rdata_b, 0);
        addr_b = 8'd2; tick(); check("w16_Z", rdata_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
